// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - RV32I opcodes, NOP and controller state encodings
package pipeline_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  function automatic logic op_writes_rd(input logic [6:0] op);
    return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP};
  endfunction

  function automatic logic op_reads_rs1(input logic [6:0] op);
    return op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
  endfunction

  function automatic logic op_reads_rs2(input logic [6:0] op);
    return op inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - combinational RAW hazard and C-stage class decode
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] instd_i,
  input  logic [WIDTH-1:0] instc_i,
  input  logic [WIDTH-1:0] instw_i,
  output logic             raw_o,
  output logic             c_is_mem_o,
  output logic             c_is_ctrl_o
);

  logic [6:0] d_op, c_op, w_op;
  logic [4:0] d_rs1, d_rs2, c_rd, w_rd;
  logic       use_rs1, use_rs2, c_wr, w_wr;
  logic       rs1_hit, rs2_hit;
  logic       unused_bits;

  assign d_op  = instd_i[6:0];
  assign d_rs1 = instd_i[19:15];
  assign d_rs2 = instd_i[24:20];
  assign c_op  = instc_i[6:0];
  assign c_rd  = instc_i[11:7];
  assign w_op  = instw_i[6:0];
  assign w_rd  = instw_i[11:7];

  // x0 is hardwired zero, so it never creates a dependency on either side
  assign use_rs1 = op_reads_rs1(d_op) && (d_rs1 != 5'd0);
  assign use_rs2 = op_reads_rs2(d_op) && (d_rs2 != 5'd0);
  assign c_wr    = op_writes_rd(c_op) && (c_rd != 5'd0);
  assign w_wr    = op_writes_rd(w_op) && (w_rd != 5'd0);

  assign rs1_hit = (c_wr && (d_rs1 == c_rd)) || (w_wr && (d_rs1 == w_rd));
  assign rs2_hit = (c_wr && (d_rs2 == c_rd)) || (w_wr && (d_rs2 == w_rd));

  assign raw_o       = (use_rs1 && rs1_hit) || (use_rs2 && rs2_hit);
  assign c_is_mem_o  = (c_op == OPC_LOAD) || (c_op == OPC_STORE);
  assign c_is_ctrl_o = (c_op == OPC_BRANCH) || (c_op == OPC_JAL) || (c_op == OPC_JALR);

  assign unused_bits = ^{instd_i[WIDTH-1:25], instd_i[14:7], instc_i[WIDTH-1:12], instw_i[WIDTH-1:12]};

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - F/D/C/W hazard, memory-wait and flush sequencing controller
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instD,
  input  logic [WIDTH-1:0] instC,
  input  logic [WIDTH-1:0] instW,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             hold_f,
  output logic             hold_d,
  output logic             hold_c,
  output logic             bubble_c,
  output logic             bubble_w,
  output logic             flush,
  output logic             mem_req,
  output logic             mem_err,
  output logic [1:0]       state
);

  localparam int             CW       = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_err_q, mem_err_d;
  logic          raw, c_is_mem, c_is_ctrl;

  hazard_detect #(.WIDTH(WIDTH)) u_hazard (
    .instd_i    (instD),
    .instc_i    (instC),
    .instw_i    (instW),
    .raw_o      (raw),
    .c_is_mem_o (c_is_mem),
    .c_is_ctrl_o(c_is_ctrl)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    hold_f    = 1'b0;
    hold_d    = 1'b0;
    hold_c    = 1'b0;
    bubble_c  = 1'b0;
    bubble_w  = 1'b0;
    flush     = 1'b0;
    mem_req   = 1'b0;

    case (state_q)
      RUN: begin
        if (c_is_mem && !mem_ready) begin
          mem_req  = 1'b1;
          hold_f   = 1'b1;
          hold_d   = 1'b1;
          hold_c   = 1'b1;
          bubble_w = 1'b1;
          state_d  = MEM_WAIT;
          cnt_d    = '0;
        end else if (c_is_mem) begin
          mem_req  = 1'b1;
          hold_f   = raw;
          hold_d   = raw;
          bubble_c = raw;
        // br_taken only arrives with a control transfer in C; D is discarded, so raw is moot
        end else if (br_taken && c_is_ctrl) begin
          flush = 1'b1;
        end else begin
          hold_f   = raw;
          hold_d   = raw;
          bubble_c = raw;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          hold_f   = raw;
          hold_d   = raw;
          bubble_c = raw;
          state_d  = RUN;
        end else begin
          hold_f   = 1'b1;
          hold_d   = 1'b1;
          hold_c   = 1'b1;
          bubble_w = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d   = ERROR;
            mem_err_d = 1'b1;
          end
        end
      end
      ERROR: begin
        hold_f   = 1'b1;
        hold_d   = 1'b1;
        hold_c   = 1'b1;
        bubble_w = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!reset) begin
      hold_f   = 1'b0;
      hold_d   = 1'b0;
      hold_c   = 1'b0;
      bubble_c = 1'b0;
      bubble_w = 1'b0;
      flush    = 1'b0;
      mem_req  = 1'b0;
    end
  end

  assign mem_err = reset && mem_err_q;
  assign state   = reset ? state_q : RUN;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - bench for pipeline_ctrl against a behavioural pipeline model
module tb_pipeline_ctrl;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] ADDI5  = 32'h00100293;
  localparam logic [31:0] ADD655 = 32'h00528333;
  localparam logic [31:0] ADD605 = 32'h00500333;
  localparam logic [31:0] ADD21  = 32'h00008133;
  localparam logic [31:0] LUI5   = 32'h005002b7;
  localparam logic [31:0] LW1    = 32'h00012083;
  localparam logic [31:0] BEQ    = 32'h00000063;

  // vector order: hold_f hold_d hold_c bubble_c bubble_w flush mem_req mem_err state[1:0]
  localparam logic [9:0] RAW_STALL = 10'b1101000000;
  localparam logic [9:0] MEM_STALL = 10'b1110101000;
  localparam logic [9:0] REQ       = 10'b0000001000;
  localparam logic [9:0] FLUSH     = 10'b0000010000;
  localparam logic [9:0] ERR_HOLD  = 10'b1110100110;

  logic        clk = 1'b1;
  logic        reset = 1'b0;
  logic [31:0] instD = NOP;
  logic [31:0] instC = NOP;
  logic [31:0] instW = NOP;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        hold_f, hold_d, hold_c, bubble_c, bubble_w, flush, mem_req, mem_err;
  logic [1:0]  state;

  int          checks = 0;
  int          errors = 0;
  int          lit_req = 0;
  int          lit_seen = 0;
  string       lit_name = "";
  logic [9:0]  lit_exp = '0;

  int          m_mode = 0;
  int          m_waits = 0;

  pipeline_ctrl #(.WIDTH(32), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .instD    (instD),
    .instC    (instC),
    .instW    (instW),
    .br_taken (br_taken),
    .mem_ready(mem_ready),
    .hold_f   (hold_f),
    .hold_d   (hold_d),
    .hold_c   (hold_c),
    .bubble_c (bubble_c),
    .bubble_w (bubble_w),
    .flush    (flush),
    .mem_req  (mem_req),
    .mem_err  (mem_err),
    .state    (state)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] dut_vec();
    return {hold_f, hold_d, hold_c, bubble_c, bubble_w, flush, mem_req, mem_err, state};
  endfunction

  function automatic bit writes_reg(input logic [31:0] i, input logic [4:0] r);
    return (r != 5'd0) && (i[11:7] == r) &&
           (i[6:0] inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33});
  endfunction

  function automatic bit depends(input logic [31:0] d, input logic [31:0] c, input logic [31:0] w);
    bit r1, r2;
    r1 = d[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    r2 = d[6:0] inside {7'h33, 7'h23, 7'h63};
    return (r1 && (writes_reg(c, d[19:15]) || writes_reg(w, d[19:15]))) ||
           (r2 && (writes_reg(c, d[24:20]) || writes_reg(w, d[24:20])));
  endfunction

  function automatic bit is_mem(input logic [31:0] i);
    return i[6:0] inside {7'h03, 7'h23};
  endfunction

  function automatic logic [9:0] model_out();
    logic [9:0] e;
    bit raw;
    e = '0;
    if (!reset) return e;
    raw = depends(instD, instC, instW);
    if (m_mode == 0) begin
      if (is_mem(instC) && !mem_ready) e = MEM_STALL;
      else if (!is_mem(instC) && br_taken) e = FLUSH;
      else e = (is_mem(instC) ? REQ : 10'd0) | (raw ? RAW_STALL : 10'd0);
    end else if (m_mode == 1) begin
      e = mem_ready ? (REQ | (raw ? RAW_STALL : 10'd0)) : MEM_STALL;
      e[1:0] = 2'd1;
    end else begin
      e = ERR_HOLD;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_mode  = 0;
      m_waits = 0;
    end else if (m_mode == 0) begin
      if (is_mem(instC) && !mem_ready) begin
        m_mode  = 1;
        m_waits = 0;
      end
    end else if (m_mode == 1) begin
      if (mem_ready) m_mode = 0;
      else begin
        m_waits++;
        if (m_waits == MEM_TIMEOUT) m_mode = 2;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (dut_vec() !== model_out()) begin
      errors++;
      $display("FAIL model_cmp t=%0t dut=%b expected=%b", $time, dut_vec(), model_out());
    end
    if (lit_req != lit_seen) begin
      lit_seen = lit_req;
      checks++;
      if (dut_vec() !== lit_exp) begin
        errors++;
        $display("FAIL %s t=%0t dut=%b expected=%b", lit_name, $time, dut_vec(), lit_exp);
      end
    end
  end

  task automatic expect_lit(input string n, input logic [9:0] v);
    lit_name = n;
    lit_exp  = v;
    lit_req++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    expect_lit("reset_idle", 10'd0); tick();
    instC = LW1;
    expect_lit("reset_masks_load", 10'd0); tick();

    reset = 1'b1; instC = ADDI5; instD = ADD655;
    expect_lit("raw_from_c", RAW_STALL); tick();
    instC = NOP; instW = ADDI5;
    expect_lit("raw_from_w", RAW_STALL); tick();
    instW = NOP;
    expect_lit("x0_no_hazard", 10'd0); tick();
    instD = ADD605; instW = ADDI5;
    expect_lit("raw_rs2_only", RAW_STALL); tick();
    instD = LUI5;
    expect_lit("lui_reads_none", 10'd0); tick();

    instD = ADD655; instC = BEQ; br_taken = 1'b1;
    expect_lit("flush_over_raw", FLUSH); tick();
    br_taken = 1'b0;
    expect_lit("raw_after_flush", RAW_STALL); tick();

    instD = NOP; instW = NOP; instC = LW1; mem_ready = 1'b0;
    expect_lit("load_c1", 10'b1110101000); tick();
    expect_lit("load_c2", 10'b1110101001); tick();
    expect_lit("load_c3", 10'b1110101001); tick();
    mem_ready = 1'b1;
    expect_lit("load_c4", 10'b0000001001); tick();
    instC = NOP; mem_ready = 1'b0;
    expect_lit("load_c5", 10'd0); tick();

    instC = LW1; instD = ADD21;
    expect_lit("mem_over_raw", MEM_STALL); tick();
    mem_ready = 1'b1;
    expect_lit("release_raw", 10'b1101001001); tick();
    instC = NOP; instW = LW1;
    expect_lit("raw_on_w_load", RAW_STALL); tick();
    instC = LW1; instW = NOP; instD = NOP;
    expect_lit("load_ready_now", REQ); tick();

    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b0;
    expect_lit("reset_mid_wait", 10'd0); tick();
    reset = 1'b1; instC = NOP;
    expect_lit("after_wait_reset", 10'd0); tick();

    instC = LW1;
    for (int i = 0; i <= MEM_TIMEOUT; i++) begin
      if (i == MEM_TIMEOUT) expect_lit("last_wait_cycle", 10'b1110101001);
      tick();
    end
    expect_lit("timeout_error", ERR_HOLD); tick();
    mem_ready = 1'b1;
    expect_lit("error_ignores_ready", ERR_HOLD); tick();
    reset = 1'b0;
    expect_lit("reset_in_error", 10'd0); tick();
    reset = 1'b1; instC = NOP; mem_ready = 1'b0;
    expect_lit("error_cleared", 10'd0); tick();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
